exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes the ID/EX register outputs directly.
- Generates operand Val2 (rotated immediate, shifted register, or memory offset) and performs ALU ops with 2-input forwarding.
- Computes the branch target and holds the NZCV status register.
- Registers results into the EX/MEM boundary with 1-cycle latency.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hold the EX/MEM register and status register (MEM stall)
- pc_in  in  32  PC+4 of the instruction in EX
- mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in  in  1 each  control from the ID/EX register
- exec_cmd_in  in  4  ALU command
- val_rn_in, val_rm_in  in  32  register operands
- signed_immed_24_in  in  24  branch offset, in words
- dest_in  in  4  destination register
- shift_operand_in  in  12  shifter field
- carry_in  in  1  C flag captured at decode
- fwd_sel_src1, fwd_sel_src2  in  2 each  00 register value, 01 mem_fwd_val, 10 wb_fwd_val, 11 register value
- mem_fwd_val, wb_fwd_val  in  32  forwarded values
- branch_taken  out  1  combinational, equals branch_taken_in
- branch_addr  out  32  combinational branch target
- status  out  4  {N,Z,C,V}, registered
- alu_res, st_val  out  32  registered
- dest  out  4  registered
- wb_en, mem_r_en, mem_w_en  out  1 each  registered

Behaviour:
- Reset (async): every registered output is 0, including status.
- Operand selection
  - op1 = mux(fwd_sel_src1) over val_rn_in.
  - rm_f = mux(fwd_sel_src2) over val_rm_in.
- Val2 selection, in priority order:
  - imm_in=1: zero-extend shift_operand_in[7:0], rotate right by 2*shift_operand_in[11:8].
  - Else if mem_r_en_in or mem_w_en_in: zero-extend shift_operand_in[11:0].
  - Else: shift rm_f by amount [11:7], type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Amount 0 means unshifted for every type (no RRX).
- ALU (exec_cmd_in), producing 32-bit result res and flags:
  - 0001 MOV: res = Val2
  - 1001 MVN: res = ~Val2
  - 0010 ADD: op1 + Val2
  - 0011 ADC: op1 + Val2 + C
  - 0100 SUB/CMP: op1 - Val2
  - 0101 SBC: op1 - Val2 - ~C, where C is carry_in
  - 0110 AND/TST: op1 & Val2
  - 0111 ORR: op1 | Val2
  - 1000 EOR: op1 ^ Val2
  - Other codes: res = 0, flags N/Z from 0, C and V unchanged.
- Flags
  - N = res[31]; Z = (res == 0).
  - Arithmetic ops: C = bit 32 of the 33-bit sum (for subtract, C = no-borrow); V = signed overflow.
  - Logic and move ops: C and V keep the current status value.
- Status register: at posedge with status_w_en_in=1 and freeze=0, load {N,Z,C,V}; otherwise hold.
- branch_addr = pc_in + (sign_extend(signed_immed_24_in) << 2), mod 2^32, combinational.
- EX/MEM register, at posedge:
  - freeze=0: capture alu_res=res, st_val=rm_f, dest, wb_en, mem_r_en, mem_w_en.
  - freeze=1: hold every field.
- Latency: 1 cycle from inputs to registered outputs; status is visible to decode the cycle after the update.
- Boundary cases:
  - Simultaneous freeze and status_w_en_in: the status register holds.
  - ADD 0xFFFFFFFF+1: res=0, Z=1, C=1, V=0.
  - Rotate by 0: immediate unrotated.
  - Forward select 11: behaves as 00.
  - rst asserted mid-operation: clears immediately, regardless of clk or freeze.

Decomposition:
- Shared package `arm_pkg` holds:
  - EXEC_* command codes
  - SHIFT_LSL/LSR/ASR/ROR
  - FWD_REG/FWD_MEM/FWD_WB
  - status bit indices N=3, Z=2, C=1, V=0
- One combinational sub-module `val2_generator` produces Val2 from imm, mem flag, shift_operand and rm_f.
- The ALU, status register and EX/MEM register stay in exe_stage.

Test Plan:
- Reset then rst=1 with freeze=1 → all outputs 0, status=0000.
- imm=1, MOV, shift_operand=0x1FF (rot 1, imm 0xFF) → next cycle alu_res=0xC000003F; status unchanged when status_w_en=0.
- SUB op1=5, rm=7 LSL 0, status_w_en=1 → alu_res=0xFFFFFFFE, status N=1 Z=0 C=0 V=0.
- ADD 0x7FFFFFFF + 1 with S → alu_res=0x80000000, status=1001; then freeze=1 with new inputs → outputs and status held.
- fwd_sel_src1=01, mem_fwd_val=0x10; LDR with offset 0x004 → alu_res=0x14, mem_r_en=1, dest propagated.
- pc_in=0x20, signed_immed_24=0xFFFFFE (-2) → branch_addr=0x18 in the same cycle; ASR of 0x80000000 by 4 → 0xF8000000.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM pipeline: ALU commands, shift types,
// forwarding selects, status bit positions and the EX/MEM boundary record.
package arm_pkg;

  localparam logic [3:0] EXEC_MOV = 4'b0001;
  localparam logic [3:0] EXEC_ADD = 4'b0010;
  localparam logic [3:0] EXEC_ADC = 4'b0011;
  localparam logic [3:0] EXEC_SUB = 4'b0100;
  localparam logic [3:0] EXEC_SBC = 4'b0101;
  localparam logic [3:0] EXEC_AND = 4'b0110;
  localparam logic [3:0] EXEC_ORR = 4'b0111;
  localparam logic [3:0] EXEC_EOR = 4'b1000;
  localparam logic [3:0] EXEC_MVN = 4'b1001;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
  } exmem_t;

endpackage

// File: rtl/val2_generator.sv
// Second-operand generator: rotated immediate, 12-bit memory offset, or
// shifted register. A zero shift amount leaves the register unshifted.
module val2_generator
  import arm_pkg::*;
(
  input  logic        imm,
  input  logic        mem_en,
  input  logic [11:0] shift_operand,
  input  logic [31:0] rm_f,
  output logic [31:0] val2
);

  logic [63:0] imm_dbl, rm_dbl;
  logic [4:0]  amt;

  assign amt     = shift_operand[11:7];
  // Rotations are done by shifting a doubled word and keeping the low half.
  assign imm_dbl = {2{24'b0, shift_operand[7:0]}} >> {shift_operand[11:8], 1'b0};
  assign rm_dbl  = {rm_f, rm_f} >> amt;

  always_comb begin
    val2 = rm_f;
    if (imm) begin
      val2 = imm_dbl[31:0];
    end else if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else begin
      case (shift_operand[6:5])
        SHIFT_LSL: val2 = rm_f << amt;
        SHIFT_LSR: val2 = rm_f >> amt;
        SHIFT_ASR: val2 = $unsigned($signed(rm_f) >>> amt);
        default:   val2 = rm_dbl[31:0];
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2, ALU with NZCV flags, branch
// target, status register and the EX/MEM pipeline register.
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic             status_w_en_in,
  input  logic             branch_taken_in,
  input  logic             imm_in,
  input  logic [3:0]       exec_cmd_in,
  input  logic [WIDTH-1:0] val_rn_in,
  input  logic [WIDTH-1:0] val_rm_in,
  input  logic [23:0]      signed_immed_24_in,
  input  logic [3:0]       dest_in,
  input  logic [11:0]      shift_operand_in,
  input  logic             carry_in,
  input  logic [1:0]       fwd_sel_src1,
  input  logic [1:0]       fwd_sel_src2,
  input  logic [WIDTH-1:0] mem_fwd_val,
  input  logic [WIDTH-1:0] wb_fwd_val,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr,
  output logic [3:0]       status,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] st_val,
  output logic [3:0]       dest,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en
);

  logic [31:0] op1, rm_f, val2, res;
  logic [32:0] sum;
  logic        fn, fz, fc, fv;
  exmem_t      exmem_q;

  always_comb begin
    case (fwd_sel_src1)
      FWD_MEM: op1 = mem_fwd_val;
      FWD_WB:  op1 = wb_fwd_val;
      default: op1 = val_rn_in;
    endcase
    case (fwd_sel_src2)
      FWD_MEM: rm_f = mem_fwd_val;
      FWD_WB:  rm_f = wb_fwd_val;
      default: rm_f = val_rm_in;
    endcase
  end

  val2_generator u_val2 (
    .imm           (imm_in),
    .mem_en        (mem_r_en_in | mem_w_en_in),
    .shift_operand (shift_operand_in),
    .rm_f          (rm_f),
    .val2          (val2)
  );

  // Subtraction runs as op1 + ~val2 + cin so bit 32 is the ARM no-borrow carry.
  always_comb begin
    sum = '0;
    res = '0;
    fc  = status[ST_C];
    fv  = status[ST_V];
    case (exec_cmd_in)
      EXEC_MOV: res = val2;
      EXEC_MVN: res = ~val2;
      EXEC_ADD, EXEC_ADC: begin
        sum = {1'b0, op1} + {1'b0, val2} + {32'b0, (exec_cmd_in == EXEC_ADC) & carry_in};
        res = sum[31:0];
        fc  = sum[32];
        fv  = (op1[31] == val2[31]) && (res[31] != op1[31]);
      end
      EXEC_SUB, EXEC_SBC: begin
        sum = {1'b0, op1} + {1'b0, ~val2} + {32'b0, (exec_cmd_in == EXEC_SUB) | carry_in};
        res = sum[31:0];
        fc  = sum[32];
        fv  = (op1[31] != val2[31]) && (res[31] != op1[31]);
      end
      EXEC_AND: res = op1 & val2;
      EXEC_ORR: res = op1 | val2;
      EXEC_EOR: res = op1 ^ val2;
      default:  res = '0;
    endcase
    fn = res[31];
    fz = (res == 32'b0);
  end

  assign branch_taken = branch_taken_in;
  assign branch_addr  = pc_in + {{6{signed_immed_24_in[23]}}, signed_immed_24_in, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status  <= '0;
      exmem_q <= '0;
    end else if (!freeze) begin
      if (status_w_en_in) status <= {fn, fz, fc, fv};
      exmem_q <= '{alu_res: res, st_val: rm_f, dest: dest_in,
                   wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in};
    end
  end

  assign alu_res  = exmem_q.alu_res;
  assign st_val   = exmem_q.st_val;
  assign dest     = exmem_q.dest;
  assign wb_en    = exmem_q.wb_en;
  assign mem_r_en = exmem_q.mem_r_en;
  assign mem_w_en = exmem_q.mem_w_en;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: expected EX/MEM contents are queued when a
// step is driven and compared one cycle later.
module tb_exe_stage;
  import arm_pkg::*;

  logic        clk = 1'b0, rst, freeze;
  logic [31:0] pc_in;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in;
  logic [3:0]  exec_cmd_in, dest_in;
  logic [31:0] val_rn_in, val_rm_in, mem_fwd_val, wb_fwd_val;
  logic [23:0] signed_immed_24_in;
  logic [11:0] shift_operand_in;
  logic        carry_in;
  logic [1:0]  fwd_sel_src1, fwd_sel_src2;
  logic        branch_taken;
  logic [31:0] branch_addr, alu_res, st_val;
  logic [3:0]  status, dest;
  logic        wb_en, mem_r_en, mem_w_en;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic [3:0]  status;
    logic        wb, mr, mw;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .imm_in(imm_in),
    .exec_cmd_in(exec_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .signed_immed_24_in(signed_immed_24_in), .dest_in(dest_in),
    .shift_operand_in(shift_operand_in), .carry_in(carry_in),
    .fwd_sel_src1(fwd_sel_src1), .fwd_sel_src2(fwd_sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
    .alu_res(alu_res), .st_val(st_val), .dest(dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    freeze = 0; pc_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
    status_w_en_in = 0; branch_taken_in = 0; imm_in = 0; exec_cmd_in = 0;
    val_rn_in = 0; val_rm_in = 0; signed_immed_24_in = 0; dest_in = 0;
    shift_operand_in = 0; carry_in = 0; fwd_sel_src1 = 0; fwd_sel_src2 = 0;
    mem_fwd_val = 0; wb_fwd_val = 0;
  endtask

  // Push the expectation for the currently driven inputs, clock once, compare.
  task automatic cycle(input string tag, input exp_t e);
    exp_t g;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, ".alu_res"},  alu_res,           g.alu);
    check({tag, ".st_val"},   st_val,            g.st);
    check({tag, ".dest"},     {28'b0, dest},     {28'b0, g.dest});
    check({tag, ".status"},   {28'b0, status},   {28'b0, g.status});
    check({tag, ".ctl"},      {29'b0, wb_en, mem_r_en, mem_w_en}, {29'b0, g.wb, g.mr, g.mw});
  endtask

  initial begin
    idle();
    rst = 1; freeze = 1;
    val_rn_in = 32'h1234; val_rm_in = 32'h5678; dest_in = 4'hF; wb_en_in = 1;
    status_w_en_in = 1; exec_cmd_in = EXEC_ADD;
    repeat (2) @(posedge clk);
    #1;
    check("reset.alu_res", alu_res, 32'h0);
    check("reset.st_val",  st_val,  32'h0);
    check("reset.status",  {28'b0, status}, 32'h0);
    check("reset.ctl",     {24'b0, dest, 1'b0, wb_en, mem_r_en, mem_w_en}, 32'h0);

    @(negedge clk); rst = 0; idle();
    // Rotated immediate 0xFF ror 2, no flag update
    imm_in = 1; exec_cmd_in = EXEC_MOV; shift_operand_in = 12'h1FF; val_rm_in = 32'h55;
    dest_in = 4'd3; wb_en_in = 1;
    cycle("mov_imm_rot", '{32'hC000003F, 32'h55, 4'd3, 4'b0000, 1, 0, 0});

    @(negedge clk); idle();
    val_rn_in = 5; val_rm_in = 7; exec_cmd_in = EXEC_SUB; status_w_en_in = 1;
    dest_in = 4'd4; wb_en_in = 1;
    cycle("sub_neg", '{32'hFFFFFFFE, 32'h7, 4'd4, 4'b1000, 1, 0, 0});

    @(negedge clk); idle();
    val_rn_in = 32'h7FFFFFFF; imm_in = 1; shift_operand_in = 12'h001; exec_cmd_in = EXEC_ADD;
    status_w_en_in = 1; dest_in = 4'd5; wb_en_in = 1; val_rm_in = 32'hAA;
    cycle("add_ovf", '{32'h80000000, 32'hAA, 4'd5, 4'b1001, 1, 0, 0});

    // Freeze with a flag-setting op pending: everything holds
    @(negedge clk); idle();
    freeze = 1; val_rn_in = 32'hFFFFFFFF; imm_in = 1; shift_operand_in = 12'h001;
    exec_cmd_in = EXEC_ADD; status_w_en_in = 1; dest_in = 4'd9; mem_w_en_in = 1; val_rm_in = 32'h1;
    cycle("freeze_hold", '{32'h80000000, 32'hAA, 4'd5, 4'b1001, 1, 0, 0});

    @(negedge clk); freeze = 0; mem_w_en_in = 0;
    cycle("add_wrap", '{32'h0, 32'h1, 4'd9, 4'b0110, 0, 0, 0});

    @(negedge clk); idle();
    fwd_sel_src1 = FWD_MEM; mem_fwd_val = 32'h10; val_rn_in = 32'hDEAD; mem_r_en_in = 1;
    exec_cmd_in = EXEC_ADD; shift_operand_in = 12'h004; dest_in = 4'd7; wb_en_in = 1;
    val_rm_in = 32'h77;
    cycle("ldr_fwd_mem", '{32'h14, 32'h77, 4'd7, 4'b0110, 1, 1, 0});

    @(negedge clk); idle();
    pc_in = 32'h20; signed_immed_24_in = 24'hFFFFFE; branch_taken_in = 1;
    val_rm_in = 32'h80000000; shift_operand_in = 12'h240; exec_cmd_in = EXEC_MOV; dest_in = 4'd1;
    #1;
    check("branch_addr_neg", branch_addr, 32'h18);
    check("branch_taken", {31'b0, branch_taken}, 32'h1);
    cycle("asr4", '{32'hF8000000, 32'h80000000, 4'd1, 4'b0110, 0, 0, 0});

    @(negedge clk); idle();
    pc_in = 32'h100; signed_immed_24_in = 24'h000010;
    fwd_sel_src1 = 2'b11; fwd_sel_src2 = 2'b11; val_rm_in = 32'h3; mem_fwd_val = 32'hBAD0;
    wb_fwd_val = 32'hBAD1; shift_operand_in = 12'h0E0; exec_cmd_in = EXEC_MOV; dest_in = 4'd2;
    mem_w_en_in = 1;
    #1;
    check("branch_addr_pos", branch_addr, 32'h140);
    check("branch_taken_lo", {31'b0, branch_taken}, 32'h0);
    // mem_w_en makes Val2 the raw 12-bit offset 0x0E0 rather than a ROR
    cycle("fwd11_str", '{32'h000000E0, 32'h3, 4'd2, 4'b0110, 0, 0, 1});

    @(negedge clk); idle();
    fwd_sel_src2 = 2'b11; val_rm_in = 32'h3; shift_operand_in = 12'h0E0; exec_cmd_in = EXEC_MOV;
    cycle("ror1", '{32'h80000001, 32'h3, 4'd0, 4'b0110, 0, 0, 0});

    @(negedge clk); idle();
    fwd_sel_src2 = FWD_WB; wb_fwd_val = 32'h100; val_rm_in = 32'hDEAD; shift_operand_in = 12'h220;
    val_rn_in = 32'hFF; exec_cmd_in = EXEC_EOR; status_w_en_in = 1; dest_in = 4'd6; wb_en_in = 1;
    cycle("eor_lsr_wb", '{32'hEF, 32'h100, 4'd6, 4'b0010, 1, 0, 0});

    @(negedge clk); idle();
    val_rn_in = 10; imm_in = 1; shift_operand_in = 12'h003; exec_cmd_in = EXEC_SBC;
    carry_in = 0; status_w_en_in = 1; dest_in = 4'd8;
    cycle("sbc", '{32'h6, 32'h0, 4'd8, 4'b0010, 0, 0, 0});

    @(negedge clk); idle();
    val_rn_in = 32'h80000000; imm_in = 1; shift_operand_in = 12'h001; exec_cmd_in = EXEC_ADC;
    carry_in = 1; status_w_en_in = 1; dest_in = 4'd8;
    cycle("adc", '{32'h80000002, 32'h0, 4'd8, 4'b1000, 0, 0, 0});

    @(negedge clk); idle();
    imm_in = 1; shift_operand_in = 12'h0F0; exec_cmd_in = EXEC_MVN; dest_in = 4'hB;
    cycle("mvn", '{32'hFFFFFF0F, 32'h0, 4'hB, 4'b1000, 0, 0, 0});

    @(negedge clk); idle();
    val_rn_in = 32'hFFFF0000; imm_in = 1; shift_operand_in = 12'h0F0; exec_cmd_in = EXEC_ORR;
    status_w_en_in = 1; dest_in = 4'hC;
    cycle("orr", '{32'hFFFF00F0, 32'h0, 4'hC, 4'b1000, 0, 0, 0});

    @(negedge clk); idle();
    val_rn_in = 32'hF0; imm_in = 1; shift_operand_in = 12'h00F; exec_cmd_in = EXEC_AND;
    status_w_en_in = 1; dest_in = 4'hD;
    cycle("tst_zero", '{32'h0, 32'h0, 4'hD, 4'b0100, 0, 0, 0});

    @(negedge clk); idle();
    val_rn_in = 32'h5; val_rm_in = 32'h9; exec_cmd_in = 4'b1111; status_w_en_in = 1;
    dest_in = 4'hA; wb_en_in = 1;
    cycle("undef_cmd", '{32'h0, 32'h9, 4'hA, 4'b0100, 1, 0, 0});

    // Asynchronous reset between clock edges while frozen
    @(negedge clk); freeze = 1;
    #2 rst = 1;
    #1;
    check("async_rst.st_val", st_val, 32'h0);
    check("async_rst.status", {28'b0, status}, 32'h0);
    check("async_rst.ctl", {24'b0, dest, 1'b0, wb_en, mem_r_en, mem_w_en}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
